// File: rtl/regbank_wr_demux8_16bit.sv
// Write side of the eight-entry register bank.
// A request is decoded by wr_addr and byte-merged against the current register
// contents. The merged word is held in a one-entry staging register. It commits
// into q[pend_addr] on the first edge where stall is low. While a write is
// staged it is exposed on pend_* so the datapath can forward it.
module regbank_wr_demux8_16bit #(
  parameter int WIDTH   = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       wr_be,
  input  logic             stall,
  input  logic             clr,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic             pend_valid,
  output logic [2:0]       pend_addr,
  output logic [WIDTH-1:0] pend_data
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] regs [8];
  logic             accept;
  logic             commit;
  logic             drop_r0;
  logic             load;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] merged;

  // Handshake and commit qualifiers. clr blocks both acceptance and commit.
  assign wr_ready = ~clr & ((state == IDLE) | ~stall);
  assign accept   = wr_valid & wr_ready;
  assign commit   = (state == HELD) & ~stall & ~clr;
  // A write to a hard-wired zero register is accepted but never staged.
  assign drop_r0  = R0_ZERO && (wr_addr == 3'd0);
  assign load     = accept & ~drop_r0;

  // The merge base is the newest value of the target register. This is the
  // staged word when it targets the same index, otherwise the committed register.
  assign base   = ((state == HELD) && (pend_addr == wr_addr)) ? pend_data : regs[wr_addr];
  assign merged = {wr_be[1] ? wr_data[WIDTH-1:8] : base[WIDTH-1:8],
                   wr_be[0] ? wr_data[7:0]       : base[7:0]};

  // Next-state decode: clear empties the stage, a load fills it, and a lone commit drains it.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (load) begin
      state_nxt = HELD;
    end else if (commit) begin
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Staging register: captures the destination and the merged word on each load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_addr <= 3'd0;
      pend_data <= '0;
    end else if (clr) begin
      pend_addr <= 3'd0;
      pend_data <= '0;
    end else if (load) begin
      pend_addr <= wr_addr;
      pend_data <= merged;
    end
  end

  // Register bank: commits the staged word; clr takes priority over a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the bank is reset because its contents drive outputs that must read zero out of reset.
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[pend_addr] <= pend_data;
    end
  end

  assign pend_valid = (state == HELD);

  assign q0 = R0_ZERO ? '0 : regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
  assign q4 = regs[4];
  assign q5 = regs[5];
  assign q6 = regs[6];
  assign q7 = regs[7];

endmodule

// File: tb/tb_regbank_wr_demux8_16bit.sv
// Bench for the write-side register bank.
// Two instances share the stimulus: one with register 0 hard-wired to zero, one with it writable.
// A behavioural model predicts every output after each clock edge. Directed literal
// checks pin the model at the scenarios of interest.
module tb_regbank_wr_demux8_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'd0;
  logic [1:0]  wr_be = 2'b00;
  logic        stall = 1'b0;
  logic        clr = 1'b0;

  // Index 0: R0_ZERO=1 build, index 1: R0_ZERO=0 build.
  logic        dready [2];
  logic [15:0] dq     [2][8];
  logic        dpv    [2];
  logic [2:0]  dpa    [2];
  logic [15:0] dpd    [2];

  int vectors = 0;
  int miscompares = 0;
  bit running = 1'b1;

  always #5 clk = ~clk;

  regbank_wr_demux8_16bit #(.WIDTH(16), .R0_ZERO(1'b1)) u_dut_r0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(dready[0]),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .stall(stall), .clr(clr),
    .q0(dq[0][0]), .q1(dq[0][1]), .q2(dq[0][2]), .q3(dq[0][3]),
    .q4(dq[0][4]), .q5(dq[0][5]), .q6(dq[0][6]), .q7(dq[0][7]),
    .pend_valid(dpv[0]), .pend_addr(dpa[0]), .pend_data(dpd[0])
  );

  regbank_wr_demux8_16bit #(.WIDTH(16), .R0_ZERO(1'b0)) u_dut_rw (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(dready[1]),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .stall(stall), .clr(clr),
    .q0(dq[1][0]), .q1(dq[1][1]), .q2(dq[1][2]), .q3(dq[1][3]),
    .q4(dq[1][4]), .q5(dq[1][5]), .q6(dq[1][6]), .q7(dq[1][7]),
    .pend_valid(dpv[1]), .pend_addr(dpa[1]), .pend_data(dpd[1])
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks the register file contents and the single uncommitted write, if any.
  logic [15:0] mq  [2][8];
  logic        mpv [2];
  logic [2:0]  mpa [2];
  logic [15:0] mpd [2];

  always @(posedge clk or negedge rst_n) begin
    logic        take;
    logic        drop;
    logic [15:0] cur;
    logic [15:0] newd;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) mq[b][i] <= 16'd0;
        mpv[b] <= 1'b0;
        mpa[b] <= 3'd0;
        mpd[b] <= 16'd0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (clr) begin
          for (int i = 0; i < 8; i++) mq[b][i] <= 16'd0;
          mpv[b] <= 1'b0;
        end else begin
          take = wr_valid && (!mpv[b] || !stall);
          drop = (b == 0) && (wr_addr == 3'd0);
          cur  = (mpv[b] && mpa[b] == wr_addr) ? mpd[b] : mq[b][wr_addr];
          newd = {wr_be[1] ? wr_data[15:8] : cur[15:8], wr_be[0] ? wr_data[7:0] : cur[7:0]};
          if (mpv[b] && !stall) mq[b][mpa[b]] <= mpd[b];
          if (take && !drop) begin
            mpv[b] <= 1'b1;
            mpa[b] <= wr_addr;
            mpd[b] <= newd;
          end else if (mpv[b] && !stall) begin
            mpv[b] <= 1'b0;
          end
        end
      end
    end
  end

  // Compare process: every cycle out of reset, shortly after the edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && running) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++)
          check($sformatf("model q%0d b%0d", i, b), dq[b][i], mq[b][i]);
        check($sformatf("model pend_valid b%0d", b), 16'(dpv[b]), 16'(mpv[b]));
        check($sformatf("model wr_ready b%0d", b), 16'(dready[b]),
              16'(!clr && (!mpv[b] || !stall)));
        if (mpv[b]) begin
          check($sformatf("model pend_addr b%0d", b), 16'(dpa[b]), 16'(mpa[b]));
          check($sformatf("model pend_data b%0d", b), dpd[b], mpd[b]);
        end
      end
    end
  end

  // Applies one cycle of inputs, consumed at the following rising edge.
  task automatic step(input logic v, input logic [2:0] a, input logic [15:0] d,
                      input logic [1:0] be, input logic st, input logic cl);
    @(negedge clk);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    stall    = st;
    clr      = cl;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 16'd0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      check($sformatf("reset q3 b%0d", b), dq[b][3], 16'd0);
      check($sformatf("reset pend_valid b%0d", b), 16'(dpv[b]), 16'd0);
    end
    rst_n = 1'b1;
    idle();

    // Sweep: back-to-back writes to every address, wr_ready held high.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 16'(11 * i), 2'b11, 1'b0, 1'b0);
      #1;
      check($sformatf("sweep wr_ready r0 a%0d", i), 16'(dready[0]), 16'd1);
      check($sformatf("sweep wr_ready rw a%0d", i), 16'(dready[1]), 16'd1);
    end
    idle();
    idle();
    for (int i = 1; i < 8; i++) check($sformatf("sweep q%0d", i), dq[0][i], 16'(11 * i));
    check("sweep q0 r0", dq[0][0], 16'd0);

    // Stall: held write visible on pend_*, second request blocked.
    step(1'b1, 3'd3, 16'hABCD, 2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd4, 16'h1234, 2'b11, 1'b1, 1'b0);
      #1;
      check("stall wr_ready", 16'(dready[0]), 16'd0);
      check("stall pend_valid", 16'(dpv[0]), 16'd1);
      check("stall pend_addr", 16'(dpa[0]), 16'd3);
      check("stall pend_data", dpd[0], 16'hABCD);
      check("stall q3 held", dq[0][3], 16'd33);
    end
    step(1'b1, 3'd4, 16'h1234, 2'b11, 1'b0, 1'b0);
    idle();
    check("stall q3 commit", dq[0][3], 16'hABCD);
    check("stall q4 not yet", dq[0][4], 16'd44);
    idle();
    check("stall q4 commit", dq[0][4], 16'h1234);

    // Byte merge with back-to-back partial writes to the same register.
    step(1'b1, 3'd5, 16'h1122, 2'b11, 1'b0, 1'b0);
    step(1'b1, 3'd5, 16'hAA00, 2'b10, 1'b0, 1'b0);
    step(1'b1, 3'd5, 16'h00BB, 2'b01, 1'b0, 1'b0);
    idle();
    idle();
    check("merge q5 r0", dq[0][5], 16'hAABB);
    check("merge q5 rw", dq[1][5], 16'hAABB);

    // No byte enables: accepted, value unchanged.
    step(1'b1, 3'd5, 16'hFFFF, 2'b00, 1'b0, 1'b0);
    idle();
    idle();
    check("be00 q5", dq[0][5], 16'hAABB);

    // Asynchronous reset mid-cycle with a write held.
    step(1'b1, 3'd6, 16'h6666, 2'b11, 1'b0, 1'b0);
    step(1'b0, 3'd0, 16'd0, 2'b00, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("areset q5", dq[0][5], 16'd0);
    check("areset q1", dq[1][1], 16'd0);
    check("areset pend_valid r0", 16'(dpv[0]), 16'd0);
    check("areset pend_valid rw", 16'(dpv[1]), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    check("areset q6 no commit", dq[0][6], 16'd0);

    // Clear priority over a commit; stall while IDLE still accepts.
    step(1'b1, 3'd1, 16'h1111, 2'b11, 1'b0, 1'b0);
    idle();
    step(1'b1, 3'd2, 16'hBEEF, 2'b11, 1'b1, 1'b0);
    #1;
    check("idle stall wr_ready", 16'(dready[0]), 16'd1);
    check("clr pre q1", dq[0][1], 16'h1111);
    step(1'b0, 3'd0, 16'd0, 2'b00, 1'b0, 1'b1);
    #1;
    check("clr wr_ready", 16'(dready[0]), 16'd0);
    idle();
    check("clr q1", dq[0][1], 16'd0);
    check("clr q2", dq[0][2], 16'd0);
    check("clr pend_valid", 16'(dpv[0]), 16'd0);
    idle();
    check("clr q2 lost", dq[0][2], 16'd0);

    // Register 0 behaviour in both builds.
    step(1'b1, 3'd0, 16'h0055, 2'b11, 1'b0, 1'b0);
    idle();
    check("r0 pend_valid r0", 16'(dpv[0]), 16'd0);
    check("r0 pend_valid rw", 16'(dpv[1]), 16'd1);
    check("r0 pend_data rw", dpd[1], 16'h0055);
    idle();
    check("r0 q0 rw", dq[1][0], 16'h0055);
    check("r0 q0 r0", dq[0][0], 16'd0);
    check("r0 pend_valid rw drained", 16'(dpv[1]), 16'd0);

    idle();
    idle();
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
